// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM state encoding and the arctangent table
// in turn units (2^32 = one full turn).
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    DONE
  } state_t;

  localparam int ATAN_N = 32;

  // round(atan(2^-i) / (2*pi) * 2^32)
  localparam logic [31:0] ATAN [ATAN_N] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

endpackage

// File: rtl/cordic_atan2_if.sv
// Start/ready/done level handshake plus Cartesian operands and angle result.
interface cordic_atan2_if #(
  parameter int WIDTH = 32
);
  logic                    start;
  logic signed [WIDTH-1:0] x;
  logic signed [WIDTH-1:0] y;
  logic                    ready;
  logic                    done;
  logic        [WIDTH-1:0] angle;

  modport master (output start, x, y, input ready, done, angle);
  modport slave  (input start, x, y, output ready, done, angle);
endinterface

// File: rtl/cordic_atan_lut.sv
// Combinational iteration index -> arctangent step, scaled to WIDTH bits.
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       i_idx,
  output logic [WIDTH-1:0] o_atan
);

  logic [31:0] w_full;

  assign w_full = ATAN[i_idx] >> (32 - WIDTH);
  assign o_atan = w_full[WIDTH-1:0];

endmodule

// File: rtl/cordic_atan2.sv
// Iterative CORDIC vectoring engine: returns atan2(y, x) as an unsigned turn
// angle, one micro-rotation per clock.
module cordic_atan2
  import cordic_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 32
) (
  input  logic clk,
  input  logic reset,
  cordic_atan2_if.slave s_if
);

  // Two guard bits absorb the negation of -2^(WIDTH-1) and the CORDIC gain.
  localparam int          XW   = WIDTH + 2;
  localparam logic [4:0]  LAST = 5'(ITERATIONS - 1);

  state_t                  r_state;
  logic [4:0]              r_iter;
  logic signed [XW-1:0]    r_x;
  logic signed [XW-1:0]    r_y;
  logic        [WIDTH-1:0] r_z;
  logic        [WIDTH-1:0] r_angle;
  logic                    r_zero;

  logic signed [XW-1:0]    w_x_ext;
  logic signed [XW-1:0]    w_y_ext;
  logic signed [XW-1:0]    w_xs;
  logic signed [XW-1:0]    w_ys;
  logic        [WIDTH-1:0] w_atan;
  logic        [WIDTH-1:0] w_z_next;
  logic                    w_y_neg;

  assign w_x_ext  = {{2{s_if.x[WIDTH-1]}}, s_if.x};
  assign w_y_ext  = {{2{s_if.y[WIDTH-1]}}, s_if.y};
  assign w_xs     = r_x >>> r_iter;
  assign w_ys     = r_y >>> r_iter;
  assign w_y_neg  = r_y[XW-1];
  assign w_z_next = w_y_neg ? (r_z - w_atan) : (r_z + w_atan);

  cordic_atan_lut #(.WIDTH(WIDTH)) u_lut (
    .i_idx  (r_iter),
    .o_atan (w_atan)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_iter  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_angle <= '0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_if.start) begin
            r_state <= ROTATE;
            r_iter  <= '0;
            r_zero  <= (s_if.x == '0) && (s_if.y == '0);
            // Left half-plane: rotate by pi first so the iterations converge.
            if (s_if.x[WIDTH-1]) begin
              r_x <= -w_x_ext;
              r_y <= -w_y_ext;
              r_z <= {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
              r_x <= w_x_ext;
              r_y <= w_y_ext;
              r_z <= '0;
            end
          end
        end
        ROTATE: begin
          if (w_y_neg) begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
          end else begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
          end
          r_z <= w_z_next;
          if (r_iter == LAST) begin
            r_angle <= r_zero ? '0 : w_z_next;
            r_iter  <= '0;
            r_state <= DONE;
          end else begin
            r_iter <= r_iter + 5'd1;
          end
        end
        DONE: begin
          if (!s_if.start) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_if.ready = (r_state == IDLE);
  assign s_if.done  = (r_state == DONE);
  assign s_if.angle = r_angle;

endmodule

// File: tb/tb_cordic_atan2.sv
// Directed bench for cordic_atan2: table of octant vectors, zero/hold,
// mid-rotation reset and a (cos, sin) round-trip sweep.
module tb_cordic_atan2;

  localparam real PI = 3.14159265358979323846;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cordic_atan2_if #(.WIDTH(32)) bus ();

  cordic_atan2 #(.WIDTH(32), .ITERATIONS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .s_if  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string             name;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic        [31:0] exp;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_tol(input string name, input logic [31:0] got, input logic [31:0] exp,
                         input int tol);
    logic [31:0] d;
    int          sd;
    d  = got - exp;
    sd = $signed(d);
    if (sd < 0) sd = -sd;
    checks++;
    if (sd > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (+-%0d)", name, got, exp, tol);
    end
  endtask

  // Accept an operation, scramble the operands after e0, wait for done.
  task automatic run_op(input logic signed [31:0] xi, input logic signed [31:0] yi,
                        output logic [31:0] ang, output int lat, output logic rdy_e0);
    @(negedge clk);
    bus.x     = xi;
    bus.y     = yi;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    rdy_e0 = bus.ready;
    @(negedge clk);
    bus.x = ~xi;
    bus.y = xi ^ 32'h5A5A_1234;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done not seen after %0d cycles", lat);
    end
    ang = bus.angle;
  endtask

  task automatic finish_op();
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_back", {31'd0, bus.ready}, 32'd1);
    chk("done_clear", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    logic [31:0] ang;
    logic [31:0] prev;
    logic [31:0] a;
    logic        rdy0;
    int          lat;
    real         r;
    real         c;
    real         s;
    int          xc;
    int          yc;

    vt[0] = '{"pos_x",     32'sd1000000000,  32'sd0,           32'd0};
    vt[1] = '{"pos_y",     32'sd0,           32'sd1000000000,  32'd1073741824};
    vt[2] = '{"neg_x",    -32'sd1000000000,  32'sd0,           32'd2147483648};
    vt[3] = '{"neg_y",     32'sd0,          -32'sd1000000000,  32'd3221225472};
    vt[4] = '{"diag_q1",   32'sd1000000000,  32'sd1000000000,  32'd536870912};
    vt[5] = '{"min_min",   32'sh80000000,    32'sh80000000,    32'd2684354560};
    vt[6] = '{"diag_q2",  -32'sd1000000000,  32'sd1000000000,  32'd1610612736};
    vt[7] = '{"diag_q4",   32'sd1000000000, -32'sd1000000000,  32'd3758096384};

    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_done",  {31'd0, bus.done},  32'd0);
    chk("rst_angle", bus.angle, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].x, vt[i].y, ang, lat, rdy0);
      chk("ready_fall_e0", {31'd0, rdy0}, 32'd0);
      chk("latency", lat, 32'd32);
      chk_tol(vt[i].name, ang, vt[i].exp, 64);
      finish_op();
    end

    // Zero vector, then start held high: DONE must persist without restart.
    run_op(32'sd0, 32'sd0, ang, lat, rdy0);
    chk("zero_angle", ang, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("hold_done",  {31'd0, bus.done},  32'd1);
      chk("hold_ready", {31'd0, bus.ready}, 32'd0);
    end
    finish_op();

    run_op(32'sd1000000000, 32'sd1000000000, prev, lat, rdy0);
    chk_tol("pre_reset_op", prev, 32'd536870912, 64);
    finish_op();

    // Reset partway through ROTATE.
    @(negedge clk);
    bus.x     = 32'sd0;
    bus.y     = 32'sd1000000000;
    bus.start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    chk("angle_held_mid", bus.angle, prev);
    chk("mid_busy", {31'd0, bus.ready}, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("mid_rst_done",  {31'd0, bus.done},  32'd0);
    chk("mid_rst_angle", bus.angle, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    run_op(32'sd0, 32'sd1000000000, ang, lat, rdy0);
    chk_tol("after_reset", ang, 32'd1073741824, 64);
    finish_op();

    // Round trip: angle -> (cos, sin) -> atan2.
    for (int k = 0; k < 256; k++) begin
      a  = 32'(k) * 32'd16777216 + 32'd40503;
      r  = real'(a) * 2.0 * PI / 4294967296.0;
      c  = $cos(r) * 1073741824.0;
      s  = $sin(r) * 1073741824.0;
      xc = $rtoi(c >= 0.0 ? c + 0.5 : c - 0.5);
      yc = $rtoi(s >= 0.0 ? s + 0.5 : s - 0.5);
      run_op(xc, yc, ang, lat, rdy0);
      chk_tol("roundtrip", ang, a, 128);
      finish_op();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
